// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one mux4 between four requesters and drives
// its select lines; a grant is held at most MAX_HOLD cycles while others wait.
module mux4_rr_arbiter #(
  parameter  int MAX_HOLD = 4,
  localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       owner;
  logic [3:0]       cand;
  logic [1:0]       start;
  logic [2:0]       pick;
  logic             hit;
  logic [1:0]       win;
  logic             take;
  logic             drop;

  // Returns {found, index} of the first set bit of c scanning k, k+1, .. mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] c, input logic [1:0] k);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = k + 2'(i);
      if (c[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // The select lines always hold the owner index while a grant is active.
  assign owner = {s1, s0};

  always_comb begin
    cand  = req;
    start = ptr;
    if (state == GRANT) begin
      cand  = req & ~gnt;
      start = owner + 2'd1;
    end
  end

  assign pick = rr_pick(cand, start);
  assign hit  = pick[2];
  assign win  = pick[1:0];

  assign take = hit && ((state == IDLE) || !req[owner] || (cnt == HOLD_MAX));
  assign drop = (state == GRANT) && !req[owner] && !hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      valid <= 1'b0;
      s0    <= 1'b0;
      s1    <= 1'b0;
      ptr   <= 2'd0;
      cnt   <= '0;
    end else if (take) begin
      state    <= GRANT;
      gnt      <= 4'b0001 << win;
      {s1, s0} <= win;
      valid    <= 1'b1;
      cnt      <= CNT_W'(1);
      ptr      <= win + 2'd1;
    end else if (drop) begin
      // Selects deliberately keep their last value so the mux does not toggle.
      state <= IDLE;
      gnt   <= 4'b0000;
      valid <= 1'b0;
      cnt   <= '0;
    end else if ((state == GRANT) && (cnt != HOLD_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one mux4 instance between four requesters.
- Grants exactly one requester at a time and drives the mux4 select lines (s0, s1) so the mux output y carries the granted requester's data input d0..d3.
- Each grant is held for at most MAX_HOLD consecutive cycles while other requests are pending, which bounds starvation.
- Sits between the requesting datapath units and the shared mux4 in the MIPS datapath.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one owner keeps the grant while another requester is waiting; legal range >= 1.
- CNT_W, $clog2(MAX_HOLD+1), width of the internal hold counter; derived, not overridden.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit i = requester i wants mux input d_i.
- gnt  output 4  registered one-hot grant; all zeros when idle.
- s0  output 1  mux4 select LSB, registered.
- s1  output 1  mux4 select MSB, registered; {s1,s0} = 00/01/10/11 selects d0/d1/d2/d3.
- valid  output 1  registered; 1 iff gnt != 0.

Behaviour:
- Reset (rst=1 at a rising edge):
  - gnt=0000, valid=0, s0=0, s1=0.
  - Priority pointer ptr=0, hold counter cnt=0, state=IDLE.
  - rst has priority over every other event.
- Internal state: two-state FSM (IDLE, GRANT); ptr is 2 bits; owner index is 2 bits.
- Winner search: first set bit of the candidate set, scanning cyclically from start index k: k, k+1, k+2, k+3 (mod 4).
- IDLE:
  - If req != 0, the winner is searched from ptr. At the next edge: gnt=onehot(winner), {s1,s0}=winner, valid=1, cnt=1, ptr=winner+1 (mod 4), state=GRANT.
  - Latency from req to gnt is 1 cycle.
  - If req == 0, stay in IDLE; s0/s1 hold their last value (no select toggling while idle).
- GRANT, owner o:
  - req[o]=0 (owner released):
    - Winner is searched among the other requesters from o+1. At the same edge, grant it (no bubble), cnt=1, ptr=winner+1.
    - If no other request: gnt=0000, valid=0, s0/s1 hold, state=IDLE.
  - req[o]=1, cnt < MAX_HOLD: keep the grant; cnt increments.
  - req[o]=1, cnt == MAX_HOLD, another req pending: switch to the winner among the others, searched from o+1; cnt=1; ptr=winner+1.
  - req[o]=1, cnt == MAX_HOLD, no other req: keep the grant; cnt saturates at MAX_HOLD (never wraps).
- MAX_HOLD=1: under contention the grant rotates every cycle.
- Invariants:
  - gnt is always one-hot or zero.
  - s0/s1 always equal the owner index when valid=1.
  - Non-owner req changes affect only the next arbitration.
- Reset mid-grant: at the next edge, all outputs and ptr return to reset values regardless of req.

Test Plan:
1. Reset:
   - rst=1 for 2 cycles with req=1111 -> gnt=0000, valid=0, {s1,s0}=00.
   - First edge after rst=0 -> gnt=0001, {s1,s0}=00, valid=1.
2. Single requester, MAX_HOLD=4: req=0100 held 10 cycles -> gnt=0100 and {s1,s0}=10 for all 10 cycles; no bubble, cnt saturates.
3. Full contention, MAX_HOLD=4: req=1111 constant -> gnt sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 again; valid=1 throughout.
4. Owner release: gnt=0001 at cycle 2, req changes to 1010 -> next edge gnt=0010, {s1,s0}=01, no idle cycle.
5. All drop: owner is 2, req=0000 -> next edge gnt=0000, valid=0, {s1,s0} stays 10. Then req=0001 -> gnt=0001 (ptr=3 scan reaches 0).
6. Reset mid-grant: gnt=0100 with cnt=2, rst pulsed 1 cycle -> gnt=0000, ptr=0. Then req=1100 -> gnt=0100.
- Every scenario: checker asserts gnt is one-hot or zero each cycle and that {s1,s0} matches the gnt index whenever valid=1.
